// File: rtl/iagu_fc_burst.sv
// FC input address generator: replays the input-piece address walk once per output piece,
// issuing bursts of IOB reads per group start. Optional tag outputs under `IAGU_FC_TAG_EN.
module iagu_fc_burst #(
    parameter int ADDR_W  = 12,
    parameter int PIECE_W = 8,
    parameter int BURST_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_agu_start,
    input  logic [ADDR_W-1:0]  i_start_addr,
    input  logic [ADDR_W-1:0]  i_addr_stride,
    input  logic [PIECE_W-1:0] i_in_piece_num,
    input  logic [PIECE_W-1:0] i_out_piece_num,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic               i_group_start,
    input  logic               i_iob_rdy,
    output logic               o_iob_ren,
    output logic [ADDR_W-1:0]  o_iob_raddr,
    output logic               o_precomp_rdy,
    output logic               o_group_load_end,
    output logic               o_busy,
`ifdef IAGU_FC_TAG_EN
    output logic               o_tag_last_in,
    output logic [PIECE_W-1:0] o_tag_out_piece,
`endif
    output logic               o_done
);

    typedef enum logic [1:0] {IDLE, WAIT_GRP, BURST, DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  start_q, start_d, stride_q, stride_d, addr_q, addr_d;
    logic [PIECE_W-1:0] in_num_q, in_num_d, out_num_q, out_num_d;
    logic [PIECE_W-1:0] in_q, in_d, out_q, out_d;
    logic [BURST_W-1:0] burst_len_q, burst_len_d, bcnt_q, bcnt_d;
    logic               pend_q, pend_d, gle_q, gle_d, done_q, done_d;
    logic               accept, last_in, last_out, burst_end, pend_nxt;

    assign accept    = (state_q == BURST) && i_iob_rdy;
    assign last_in   = (in_q == in_num_q - PIECE_W'(1));
    assign last_out  = (out_q == out_num_q - PIECE_W'(1));
    assign burst_end = (bcnt_q == burst_len_q - BURST_W'(1));

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        stride_d    = stride_q;
        in_num_d    = in_num_q;
        out_num_d   = out_num_q;
        burst_len_d = burst_len_q;
        addr_d      = addr_q;
        in_d        = in_q;
        out_d       = out_q;
        bcnt_d      = bcnt_q;
        pend_d      = pend_q;
        pend_nxt    = pend_q | i_group_start;
        gle_d       = 1'b0;
        done_d      = 1'b0;

        if (i_agu_start) begin
            // Zero counts are stored as one so the terminal compares never underflow.
            start_d     = i_start_addr;
            stride_d    = i_addr_stride;
            in_num_d    = (i_in_piece_num == '0) ? PIECE_W'(1) : i_in_piece_num;
            out_num_d   = (i_out_piece_num == '0) ? PIECE_W'(1) : i_out_piece_num;
            burst_len_d = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
            addr_d      = i_start_addr;
            in_d        = '0;
            out_d       = '0;
            bcnt_d      = '0;
            pend_d      = 1'b0;
            state_d     = WAIT_GRP;
        end else begin
            case (state_q)
                WAIT_GRP: begin
                    if (i_group_start) begin
                        bcnt_d  = '0;
                        state_d = BURST;
                    end
                end
                BURST: begin
                    pend_d = pend_nxt;
                    if (accept) begin
                        bcnt_d = bcnt_q + BURST_W'(1);
                        if (last_in) begin
                            in_d   = '0;
                            addr_d = start_q;
                            out_d  = out_q + PIECE_W'(1);
                        end else begin
                            in_d   = in_q + PIECE_W'(1);
                            addr_d = addr_q + stride_q;
                        end
                        if (last_in && last_out) begin
                            done_d  = 1'b1;
                            gle_d   = 1'b1;
                            bcnt_d  = '0;
                            pend_d  = 1'b0;
                            state_d = DONE;
                        end else if (burst_end) begin
                            // A queued group start chains straight into the next burst.
                            gle_d   = 1'b1;
                            bcnt_d  = '0;
                            pend_d  = 1'b0;
                            state_d = pend_nxt ? BURST : WAIT_GRP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            start_q     <= '0;
            stride_q    <= '0;
            in_num_q    <= '0;
            out_num_q   <= '0;
            burst_len_q <= '0;
            addr_q      <= '0;
            in_q        <= '0;
            out_q       <= '0;
            bcnt_q      <= '0;
            pend_q      <= 1'b0;
            gle_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stride_q    <= stride_d;
            in_num_q    <= in_num_d;
            out_num_q   <= out_num_d;
            burst_len_q <= burst_len_d;
            addr_q      <= addr_d;
            in_q        <= in_d;
            out_q       <= out_d;
            bcnt_q      <= bcnt_d;
            pend_q      <= pend_d;
            gle_q       <= gle_d;
            done_q      <= done_d;
        end
    end

    assign o_iob_ren        = (state_q == BURST);
    assign o_iob_raddr      = o_iob_ren ? addr_q : '0;
    assign o_precomp_rdy    = (state_q == WAIT_GRP) || (state_q == BURST);
    assign o_busy           = (state_q != IDLE);
    assign o_group_load_end = gle_q;
    assign o_done           = done_q;

`ifdef IAGU_FC_TAG_EN
    assign o_tag_last_in   = o_iob_ren && last_in;
    assign o_tag_out_piece = o_iob_ren ? out_q : '0;
`endif

endmodule

// File: doc/iagu_fc_burst.md
Name: iagu_fc_burst

Overview:
- Parametrised FC input address generator feeding the IOB read port of the NPU core.
- Walks input pieces × output pieces. The input-vector address sequence is replayed once per output piece.
- Each group start issues a configurable burst of reads with programmable stride, under a ready/stall handshake.
- Sits between the layer controller (start/group handshake) and the IOB read arbiter.

Parameters:
- ADDR_W, 12, IOB address width.
- PIECE_W, 8, width of piece counters and piece-count inputs.
- BURST_W, 4, width of burst-length input.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_agu_start  in  1  pulse; latches config, arms engine.
- i_start_addr  in  ADDR_W  first input-piece address.
- i_addr_stride  in  ADDR_W  address increment between input pieces.
- i_in_piece_num  in  PIECE_W  input pieces per output piece (0 treated as 1).
- i_out_piece_num  in  PIECE_W  output pieces (0 treated as 1).
- i_burst_len  in  BURST_W  reads per group (0 treated as 1).
- i_group_start  in  1  pulse; request one burst.
- i_iob_rdy  in  1  IOB accepts read this cycle.
- o_iob_ren  out  1  read request valid.
- o_iob_raddr  out  ADDR_W  read address; 0 when o_iob_ren low.
- o_precomp_rdy  out  1  engine armed and not finished.
- o_group_load_end  out  1  pulse; last read of a burst accepted.
- o_busy  out  1  state != IDLE.
- o_done  out  1  pulse; final read of the layer accepted.

Behaviour:
- Reset is decided: i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values: all outputs 0, state IDLE, counters 0.
- Config inputs are latched only on i_agu_start; later changes are ignored.
- States: IDLE, WAIT_GRP, BURST, DONE.
- i_agu_start in any state:
  - addr<=start, in/out counters<=0, burst counter<=0, pending<=0.
  - Next state WAIT_GRP. No o_done, even if aborting a burst.
- WAIT_GRP: i_group_start -> BURST next cycle. Group start at cycle N gives o_iob_ren high at N+1 (registered).
- BURST:
  - o_iob_ren=1, o_iob_raddr=current addr.
  - A read is accepted on ren & rdy. When rdy=0, addr and ren hold stable.
- On each accept:
  - If in==in_num-1: in<=0, addr<=start, out<=out+1.
  - Otherwise: in+=1, addr<=addr+stride (modulo 2^ADDR_W, carry dropped).
  - Burst counter += 1.
- Final read = accepted with in==in_num-1 and out==out_num-1:
  - o_done and o_group_load_end pulse in the following cycle. State -> DONE.
  - Any remaining burst beats are truncated.
- Burst end (counter reaches burst_len) without final read:
  - o_group_load_end pulses.
  - Goes to BURST again if pending=1 (pending cleared, no idle cycle), else WAIT_GRP.
- i_group_start while in BURST sets pending. A second one while pending=1 is dropped.
- i_group_start in IDLE or DONE is ignored.
- Simultaneous i_agu_start and i_group_start: agu_start wins and the group start is dropped.
- o_precomp_rdy=1 in WAIT_GRP and BURST, 0 in IDLE and DONE.
- DONE holds until the next i_agu_start.
- Asynchronous reset mid-burst: immediate IDLE with ren low.

Optional Feature:
IAGU_FC_TAG_EN:
- When defined, adds outputs o_tag_last_in (1) and o_tag_out_piece (PIECE_W), registered and aligned with o_iob_ren.
- o_tag_last_in is high when the current read is the last input piece.
- o_tag_out_piece carries the current out counter.
- Both are 0 when ren is low or in reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- start=0x100, stride=1, in=3, out=2, burst=1, six single-cycle group starts, rdy=1 -> addresses 100,101,102,100,101,102; o_done one cycle after the 6th accept; o_precomp_rdy falls then.
- start=0x010, stride=4, in=4, out=1, burst=4, one group start -> ren on 4 consecutive cycles, addresses 010,014,018,01C; o_group_load_end and o_done pulse together.
- Same config with rdy low on 2nd beat for 3 cycles -> addr 014 held 4 cycles; total 4 accepts; no duplicate or skipped address.
- start=0xFFE, stride=1, in=4 -> addresses FFE,FFF,000,001 (wrap).
- burst=2, in=5, out=1, second group start during the first burst, third during the first burst -> the third is dropped; the bursts run back-to-back as 2+2 reads; WAIT_GRP reached with in=4.
- i_agu_start asserted mid-burst with new start=0x200 -> next group reads from 200, no o_done; async reset mid-burst -> ren=0 immediately, all outputs 0.
